// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester and its watchdog.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Watchdog counting ACCESS cycles that end with PREADY low; flags the last allowed one.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // expired is combinational so the FSM can abort on the same edge that closes the last cycle
  generate
    if (TIMEOUT == 0) begin : g_no_wdog
      assign expired = 1'b0;
    end else begin : g_wdog
      assign expired = inc && (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one valid/ready command becomes one SETUP/ACCESS transfer and one response pulse.
// Command port: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_valid must hold until then.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [1:0]            dbg_state
);

  apb_state_e state;
  logic       wdog_expired;

  assign cmd_ready = (state == IDLE);
  assign dbg_state = state;

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (state == SETUP),
    .inc     ((state == ACCESS) && !PREADY),
    .expired (wdog_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state  <= SETUP;
            PSEL   <= 1'b1;
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          // PREADY is checked first so a completion on the expiry edge is not lost
          if (PREADY) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
          end else if (wdog_expired) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: driver tasks push expected responses, a monitor pops and compares.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int STUCK = 255;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [1:0]    dbg_state;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [DW+1:0] exp_q[$];
  int            exp_cyc_q[$];

  // current transfer as seen by the bench (latched at acceptance)
  logic          cur_write = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  int            cur_t = 0;
  int            cur_wait = STUCK;
  logic [DW-1:0] cur_rdata = '0;
  logic          cur_err = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- slave model ----------------
  int acc_idx;
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_idx <= 0;
    else if (PSEL && PENABLE && !PREADY) acc_idx <= acc_idx + 1;
    else acc_idx <= 0;
  end
  assign PREADY  = PSEL && PENABLE && (acc_idx == cur_wait);
  assign PRDATA  = cur_rdata;
  assign PSLVERR = cur_err && PSEL && PENABLE;

  // ---------------- monitor ----------------
  always @(negedge PCLK) begin
    if (PRESETn) begin
      check("cmd_ready_only_idle", {71'd0, cmd_ready}, {71'd0, !PSEL});
      check("bus_fields", {7'd0, PWRITE, PADDR, PWDATA}, {7'd0, cur_write, cur_addr, cur_wdata});
      if (PSEL) check("penable_timing", {71'd0, PENABLE}, {71'd0, (cyc >= cur_t + 2)});
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {71'd0, rsp_valid}, 72'd0);
      end else begin
        logic [DW+1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("rsp_fields", {38'd0, rsp_timeout, rsp_err, rsp_rdata}, {38'd0, e});
        check("rsp_cycle", 72'(cyc), 72'(ec));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int waits, input logic [DW-1:0] rdata, input logic err,
                       input logic expect_rsp, input logic exp_to, output int t_acc);
    int guard;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    guard = 0;
    while (!cmd_ready) begin
      @(negedge PCLK);
      guard++;
      if (guard > 50) begin
        check("accept_timeout", 72'(guard), 72'd0);
        cmd_valid = 1'b0;
        t_acc = -1;
        return;
      end
    end
    t_acc = cyc;
    @(posedge PCLK);
    cur_write = wr;
    cur_addr  = addr;
    cur_wdata = wdata;
    cur_t     = t_acc;
    cur_wait  = waits;
    cur_rdata = rdata;
    cur_err   = err;
    if (expect_rsp) begin
      if (exp_to) begin
        exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
        exp_cyc_q.push_back(t_acc + 2 + TO);
      end else begin
        exp_q.push_back({1'b0, err, (wr ? {DW{1'b0}} : rdata)});
        exp_cyc_q.push_back(t_acc + 3 + waits);
      end
    end
    @(negedge PCLK);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge PCLK);
      guard++;
    end
    check("drain_empty", 72'(exp_q.size()), 72'd0);
    repeat (2) @(negedge PCLK);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, t1, t2;

    // reset state
    repeat (2) @(negedge PCLK);
    check("rst_psel_penable", {70'd0, PSEL, PENABLE}, 72'd0);
    check("rst_rsp", {37'd0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 72'd0);
    check("rst_bus", {7'd0, PWRITE, PADDR, PWDATA}, 72'd0);
    check("rst_cmd_ready", {71'd0, cmd_ready}, 72'd1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // write, zero wait states
    issue(1'b1, 32'h4, 32'hDEADBEEF, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, t0);
    cmd_valid = 1'b0;
    check("wr_psel_t1", {70'd0, PSEL, PENABLE}, {70'd0, 2'b10});
    @(negedge PCLK);
    check("wr_penable_t2", {70'd0, PSEL, PENABLE}, {70'd0, 2'b11});
    drain();

    // read, two wait states
    issue(1'b0, 32'h8, 32'h0, 2, 32'h12345678, 1'b0, 1'b1, 1'b0, t0);
    cmd_valid = 1'b0;
    drain();

    // slave error on a read
    issue(1'b0, 32'h10, 32'h0, 1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, t0);
    cmd_valid = 1'b0;
    drain();

    // watchdog abort with PREADY stuck low
    issue(1'b0, 32'h20, 32'h0, STUCK, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, t0);
    cmd_valid = 1'b0;
    drain();

    // PREADY rises in the last allowed ACCESS cycle: normal completion wins
    issue(1'b0, 32'h24, 32'h0, TO - 1, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b0, t0);
    cmd_valid = 1'b0;
    drain();

    // reset in the middle of ACCESS: no response, cmd_ready back after release
    issue(1'b1, 32'h30, 32'h1111_2222, STUCK, 32'h0, 1'b0, 1'b0, 1'b0, t0);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_rst_in_access", {70'd0, PSEL, PENABLE}, {70'd0, 2'b11});
    PRESETn = 1'b0;
    #1;
    check("rst_async_drop", {70'd0, PSEL, PENABLE}, 72'd0);
    cur_write = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (6) @(negedge PCLK);
    check("post_rst_cmd_ready", {71'd0, cmd_ready}, 72'd1);
    check("post_rst_no_rsp", 72'(exp_q.size()), 72'd0);

    // back-to-back with cmd_valid held high
    issue(1'b1, 32'h40, 32'h0000_0040, 0, 32'h0, 1'b0, 1'b1, 1'b0, t0);
    issue(1'b0, 32'h44, 32'h0, 0, 32'h4444_4444, 1'b0, 1'b1, 1'b0, t1);
    issue(1'b1, 32'h48, 32'h0000_0048, 0, 32'h0, 1'b0, 1'b1, 1'b0, t2);
    cmd_valid = 1'b0;
    check("b2b_spacing_1", 72'(t1 - t0), 72'd3);
    check("b2b_spacing_2", 72'(t2 - t1), 72'd3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB3 requester that turns a simple valid/ready command port into APB SETUP/ACCESS transfers and returns one registered response per command. It is the initiator that drives the team's APB slave peripherals, including the APB RAM and timer register blocks, from a local controller or testbench sequencer. Each transfer supports PREADY wait states, PSLVERR capture, and an optional watchdog that aborts a transfer stuck in ACCESS.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata
- TIMEOUT, 16, maximum number of ACCESS cycles with PREADY low before abort; 0 disables the watchdog

Ports:
- PCLK  in  1  single clock; all flops on the rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command can be accepted (high exactly in IDLE)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR sampled at completion
- rsp_timeout  out  1  transfer aborted by the watchdog
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1 each  APB completion and error

## Operation
- FSM states and transitions:
  - IDLE: on cmd_valid && cmd_ready, go to SETUP.
  - SETUP: go to ACCESS unconditionally.
  - ACCESS with PREADY high: go to IDLE (normal completion).
  - ACCESS with PREADY low and the watchdog expired: go to IDLE (abort).
  - ACCESS otherwise: stay in ACCESS.
- Acceptance registers cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA. These hold stable through SETUP and ACCESS.
- After a transfer, PWRITE, PADDR and PWDATA retain their last values. They never toggle while PSEL is low.
- Output decode:
  - PSEL = 1 in SETUP and ACCESS.
  - PENABLE = 1 in ACCESS only.
  - cmd_ready = (state == IDLE), decoded combinationally from the state register.
- Normal completion (PREADY high in ACCESS):
  - Next cycle: rsp_valid = 1 and rsp_err = PSLVERR.
  - rsp_rdata = PRDATA for a read, 0 for a write.
  - rsp_timeout = 0.
- Watchdog:
  - The counter clears on entry to ACCESS and increments for each ACCESS cycle ending with PREADY low.
  - The transfer aborts when PREADY is low at the edge closing the TIMEOUT-th ACCESS cycle.
  - Abort response, next cycle: rsp_valid = 1, rsp_timeout = 1, rsp_err = 0, rsp_rdata = 0.
  - If PREADY is high on that same edge, normal completion wins.
  - Counter width is $clog2(TIMEOUT+1), minimum 1 bit.
- rsp_valid, rsp_err and rsp_timeout are pulses that are 0 in every other cycle. rsp_rdata holds its value until the next response.
- cmd_valid while not in IDLE is ignored. The command must be held until accepted.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the counter all 0. cmd_ready reads 1 under reset, but nothing is accepted while PRESETn is low.
- Reset mid-transfer: PSEL and PENABLE drop asynchronously and no response is issued for the lost command.

## Timing
- Command accepted at the edge ending cycle T. SETUP in T+1, ACCESS from T+2.
- Zero wait states: rsp_valid in T+3, and cmd_ready is high again in T+3.
- N wait states: rsp_valid in T+3+N.
- Maximum throughput is one transfer per 3 cycles.
- Abort: rsp_valid arrives TIMEOUT cycles after ACCESS entry, i.e. in T+2+TIMEOUT.

## Structure
- Shared package apb_pkg holds:
  - typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS}
  - localparam TIMEOUT_DEFAULT = 16
- Sub-module apb_timeout_cnt (parameter TIMEOUT):
  - Inputs: clr, inc.
  - Output: expired, high when the count equals TIMEOUT-1 and inc is high.
  - expired is tied 0 when TIMEOUT = 0.
- FSM and response registers live in apb_master.

## Test plan
- Write, zero wait: addr 0x4, wdata 0xDEADBEEF, PREADY tied 1 → PSEL in T+1, PENABLE in T+2, rsp_valid in T+3 with rsp_err 0 and rsp_rdata 0.
- Read, 2 wait states: addr 0x8, slave returns 0x12345678 → PADDR stable across all ACCESS cycles, rsp_valid in T+5, rsp_rdata 0x12345678.
- Slave error: PSLVERR = 1 with PREADY → rsp_valid with rsp_err = 1, rsp_timeout = 0.
- Timeout, TIMEOUT = 4, PREADY stuck low → abort and rsp_valid in T+6 with rsp_timeout = 1. A second run with PREADY rising in the 4th ACCESS cycle completes normally.
- Reset mid-ACCESS: PRESETn low in T+3 → PSEL and PENABLE drop immediately, no rsp_valid, cmd_ready = 1 after release.
- Back-to-back: cmd_valid held high with 3 commands → accepts spaced exactly 3 cycles apart, 3 responses in order, no cmd_ready pulse outside IDLE.
